// File: rtl/apu_envelope_seq.sv
// apu_envelope_seq: per-channel raw volumes (3 envelopes + wave level), registered outputs.
// Optional: APU_ENV_ZOMBIE_EN enables volume modification on envelope register writes.
module apu_envelope_seq #(
  parameter int TIMER_ZERO_AS = 8,
  parameter int WAVE_FULL     = 15
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        env_tick,
  input  logic [3:0]  trig,
  input  logic [3:0]  ch_on,
  input  logic [7:0]  nr12,
  input  logic [7:0]  nr22,
  input  logic [7:0]  nr42,
  input  logic [1:0]  nr32_level,
  input  logic [2:0]  nrx2_wr,
  output logic [15:0] volumes_raw,
  output logic [3:0]  dac_off
);
  logic [3:0]  env_d [3];
  logic [3:0]  wave_v;
  logic [15:0] volumes_d, volumes_q;
  logic [3:0]  dac_d, dac_q;
  logic        unused_ok;
  assign unused_ok = ^{trig[2], nrx2_wr};
  for (genvar e = 0; e < 3; e++) begin : g_env
    localparam int B = (e == 2) ? 3 : e;
    logic [7:0] r;
    logic [3:0] vol_q, vol_d, tmr_q, tmr_d;
    logic [2:0] per_q, per_d;
    logic       dir_q, dir_d, stop_q, stop_d;
`ifdef APU_ENV_ZOMBIE_EN
    logic [3:0] zv;
`endif
    assign r = (e == 0) ? nr12 : (e == 1) ? nr22 : nr42;
    assign env_d[e] = vol_d;
    always_comb begin
      vol_d  = vol_q;
      tmr_d  = tmr_q;
      per_d  = per_q;
      dir_d  = dir_q;
      stop_d = stop_q;
`ifdef APU_ENV_ZOMBIE_EN
      zv     = vol_q;
`endif
      if (trig[B]) begin
        vol_d  = r[7:4];
        dir_d  = r[3];
        per_d  = r[2:0];
        tmr_d  = (r[2:0] == 3'd0) ? 4'(TIMER_ZERO_AS) : {1'b0, r[2:0]};
        stop_d = 1'b0;
      end
`ifdef APU_ENV_ZOMBIE_EN
      else if (nrx2_wr[e] && ch_on[B]) begin
        if (per_q == 3'd0 && !stop_q) zv = vol_q + 4'd1;
        else if (!dir_q) zv = vol_q + 4'd2;
        vol_d = (r[3] != dir_q) ? 4'd0 - zv : zv;
        dir_d = r[3];
        per_d = r[2:0];
      end
`endif
      else if (env_tick && per_q != 3'd0 && !stop_q) begin
        if (tmr_q > 4'd1) tmr_d = tmr_q - 4'd1;
        else begin
          tmr_d = {1'b0, per_q};
          if (dir_q && vol_q != 4'd15) vol_d = vol_q + 4'd1;
          else if (!dir_q && vol_q != 4'd0) vol_d = vol_q - 4'd1;
          else stop_d = 1'b1;
        end
      end
    end
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        vol_q  <= 4'd0;
        tmr_q  <= 4'd0;
        per_q  <= 3'd0;
        dir_q  <= 1'b0;
        stop_q <= 1'b0;
      end else begin
        vol_q  <= vol_d;
        tmr_q  <= tmr_d;
        per_q  <= per_d;
        dir_q  <= dir_d;
        stop_q <= stop_d;
      end
    end
  end
  always_comb begin
    wave_v = (nr32_level == 2'd0) ? 4'd0 :
             (nr32_level == 2'd1) ? 4'(WAVE_FULL) :
             (nr32_level == 2'd2) ? 4'(WAVE_FULL >> 1) : 4'(WAVE_FULL >> 2);
    volumes_d = {ch_on[3] ? env_d[2] : 4'h0, ch_on[2] ? wave_v : 4'h0,
                 ch_on[1] ? env_d[1] : 4'h0, ch_on[0] ? env_d[0] : 4'h0};
    dac_d = {nr42[7:3] == 5'd0, nr32_level == 2'd0, nr22[7:3] == 5'd0, nr12[7:3] == 5'd0};
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      volumes_q <= 16'h0000;
      dac_q     <= 4'b1111;
    end else begin
      volumes_q <= volumes_d;
      dac_q     <= dac_d;
    end
  end
  assign volumes_raw = volumes_q;
  assign dac_off     = dac_q;
endmodule

// File: tb/tb_apu_envelope_seq.sv
// tb_apu_envelope_seq: directed plan checks plus random stimulus against an integer reference model.
module tb_apu_envelope_seq;
  logic        clk = 0;
  logic        n_reset = 1;
  logic        env_tick = 0;
  logic [3:0]  trig = 0, ch_on = 0;
  logic [7:0]  nr12 = 0, nr22 = 0, nr42 = 0;
  logic [1:0]  nr32_level = 0;
  logic [2:0]  nrx2_wr = 0;
  logic [15:0] volumes_raw;
  logic [3:0]  dac_off;
  int nvec = 0, nerr = 0;
  int mv[3], mt[3], md[3], mp[3], ms[3];
  int wl[4] = '{0, 15, 7, 3};

  apu_envelope_seq dut (
    .clk(clk), .n_reset(n_reset), .env_tick(env_tick), .trig(trig), .ch_on(ch_on),
    .nr12(nr12), .nr22(nr22), .nr42(nr42), .nr32_level(nr32_level), .nrx2_wr(nrx2_wr),
    .volumes_raw(volumes_raw), .dac_off(dac_off)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int regv(input int e);
    return (e == 0) ? int'(nr12) : (e == 1) ? int'(nr22) : int'(nr42);
  endfunction

  function automatic int bit_of(input int e);
    return (e == 2) ? 3 : e;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 3; e++) begin
      mv[e] = 0; mt[e] = 0; md[e] = 0; mp[e] = 0; ms[e] = 0;
    end
  endtask

  // Applies the envelope rules for one clock using the inputs held across the edge.
  task automatic model_step();
    for (int e = 0; e < 3; e++) begin
      int r, v;
      bit zombie;
      r = regv(e);
      zombie = 0;
`ifdef APU_ENV_ZOMBIE_EN
      zombie = nrx2_wr[e] && ch_on[bit_of(e)];
`endif
      if (trig[bit_of(e)]) begin
        mv[e] = r / 16; md[e] = (r / 8) % 2; mp[e] = r % 8;
        mt[e] = (mp[e] == 0) ? 8 : mp[e]; ms[e] = 0;
      end else if (zombie) begin
        v = mv[e];
        if (mp[e] == 0 && ms[e] == 0) v = (v + 1) % 16;
        else if (md[e] == 0) v = (v + 2) % 16;
        if ((r / 8) % 2 != md[e]) v = (16 - v) % 16;
        mv[e] = v; md[e] = (r / 8) % 2; mp[e] = r % 8;
      end else if (env_tick && mp[e] != 0 && ms[e] == 0) begin
        if (mt[e] > 1) mt[e]--;
        else begin
          mt[e] = mp[e];
          if (md[e] == 1 && mv[e] < 15) mv[e]++;
          else if (md[e] == 0 && mv[e] > 0) mv[e]--;
          else ms[e] = 1;
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_vols();
    int n[4];
    n[0] = ch_on[0] ? mv[0] : 0;
    n[1] = ch_on[1] ? mv[1] : 0;
    n[2] = ch_on[2] ? wl[nr32_level] : 0;
    n[3] = ch_on[3] ? mv[2] : 0;
    return 16'(n[0] + 16 * n[1] + 256 * n[2] + 4096 * n[3]);
  endfunction

  function automatic logic [15:0] exp_dac();
    int d;
    d = (nr12 / 8 == 0 ? 1 : 0) + (nr22 / 8 == 0 ? 2 : 0) +
        (nr32_level == 0 ? 4 : 0) + (nr42 / 8 == 0 ? 8 : 0);
    return 16'(d);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    chk("volumes", volumes_raw, exp_vols());
    chk("dac_off", {12'h0, dac_off}, exp_dac());
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      env_tick = 1; cycle();
      env_tick = 0; cycle();
    end
  endtask

  task automatic fire(input logic [3:0] t);
    trig = t; cycle(); trig = 0;
  endtask

  initial begin
    #1 n_reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vols", volumes_raw, 16'h0000);
    chk("rst_dac", {12'h0, dac_off}, 16'h000F);
    n_reset = 1;
    cycle();

    nr12 = 8'hF3; ch_on = 4'b0001;
    fire(4'b0001);
    chk("p1_init", {12'h0, volumes_raw[3:0]}, 16'hF);
    chk("p1_dac", {15'h0, dac_off[0]}, 16'h0);
    tick_n(3);
    chk("p1_3tick", {12'h0, volumes_raw[3:0]}, 16'hE);
    tick_n(42);
    chk("p1_45tick", {12'h0, volumes_raw[3:0]}, 16'h0);
    tick_n(4);
    chk("p1_floor", {12'h0, volumes_raw[3:0]}, 16'h0);

    nr22 = 8'h09; ch_on = 4'b0011;
    fire(4'b0010);
    chk("p2_init", {12'h0, volumes_raw[7:4]}, 16'h0);
    chk("p2_dac", {15'h0, dac_off[1]}, 16'h0);
    for (int k = 1; k <= 20; k++) begin
      env_tick = 1; cycle(); env_tick = 0;
      chk("p2_ramp", {12'h0, volumes_raw[7:4]}, 16'((k > 15) ? 15 : k));
    end

    nr42 = 8'hA0; ch_on = 4'b1011;
    fire(4'b1000);
    tick_n(10);
    chk("nz_per0", {12'h0, volumes_raw[15:12]}, 16'hA);
    nr42 = 8'hA1;
    fire(4'b1000);
    env_tick = 1; cycle(); env_tick = 0;
    chk("nz_step", {12'h0, volumes_raw[15:12]}, 16'h9);
    trig = 4'b1000; env_tick = 1; cycle(); trig = 0; env_tick = 0;
    chk("nz_trig_tick", {12'h0, volumes_raw[15:12]}, 16'hA);
    env_tick = 1; cycle(); env_tick = 0;
    chk("nz_restart", {12'h0, volumes_raw[15:12]}, 16'h9);

    ch_on = 4'b0100;
    for (int l = 0; l < 4; l++) begin
      nr32_level = 2'(l); cycle();
      chk("wave_lvl", {12'h0, volumes_raw[11:8]}, 16'(wl[l]));
      chk("wave_dac", {15'h0, dac_off[2]}, 16'(l == 0 ? 1 : 0));
    end
    nr32_level = 2'd1; ch_on = 4'b0000; cycle();
    chk("wave_off", {12'h0, volumes_raw[11:8]}, 16'h0);

    nr12 = 8'h52; ch_on = 4'b0001;
    fire(4'b0001);
    nr12 = 8'h5A; nrx2_wr = 3'b001; cycle(); nrx2_wr = 0;
`ifdef APU_ENV_ZOMBIE_EN
    chk("zombie", {12'h0, volumes_raw[3:0]}, 16'h9);
`else
    chk("zombie", {12'h0, volumes_raw[3:0]}, 16'h5);
`endif

    for (int i = 0; i < 3000; i++) begin
      trig = 0; nrx2_wr = 0;
      for (int b = 0; b < 4; b++) if ($urandom % 40 == 0) trig[b] = 1;
      env_tick = ($urandom % 3 == 0);
      if ($urandom % 50 == 0) ch_on = 4'($urandom);
      if ($urandom % 100 == 0) nr32_level = 2'($urandom);
      if ($urandom % 60 == 0) begin nr12 = 8'($urandom); nrx2_wr[0] = 1; end
      if ($urandom % 60 == 0) begin nr22 = 8'($urandom); nrx2_wr[1] = 1; end
      if ($urandom % 60 == 0) begin nr42 = 8'($urandom); nrx2_wr[2] = 1; end
      if ($urandom % 150 == 0) nr12 = 8'($urandom);
      cycle();
    end
    trig = 0; nrx2_wr = 0; env_tick = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/apu_envelope_seq.md
Name: apu_envelope_seq

Overview:
- Per-channel volume source for the APU. Produces the packed 16-bit raw volume word consumed by the master-volume/panning scaler.
  - Pulse1, pulse2 and noise: 4-bit volume envelopes stepped by the 64 Hz frame-sequencer tick.
  - Pattern (wave) channel: fixed level derived from its 2-bit output-level code.
- Sits between the APU register file / frame sequencer and the volume scaling stage.

Parameters:
- TIMER_ZERO_AS, 8, timer reload value used when the latched period is 0 (period 0 itself disables stepping).
- WAVE_FULL, 15, raw volume emitted for the wave level code 2'b01 (100%).

Ports:
- clk  input  1  system clock
- n_reset  input  1  asynchronous active-low reset
- env_tick  input  1  one-clk pulse at 64 Hz from the frame sequencer
- trig  input  4  one-clk trigger pulses: [0] pulse1, [1] pulse2, [2] wave, [3] noise
- ch_on  input  4  channel-active flags, same bit order
- nr12  input  8  pulse1 envelope register: [7:4] init volume, [3] dir (1=up), [2:0] period
- nr22  input  8  pulse2 envelope register, same layout
- nr42  input  8  noise envelope register, same layout
- nr32_level  input  2  wave output level: 00 mute, 01 100%, 10 50%, 11 25%
- nrx2_wr  input  3  one-clk write strobes for nr12/nr22/nr42 (bits 0/1/2)
- volumes_raw  output  16  {noise, wave, pulse2, pulse1} 4-bit raw volumes
- dac_off  output  4  1 when that channel's DAC is disabled (same bit order)

Behaviour:
- Reset (async, n_reset low): volume regs, timers, latched dir/period and stopped flags all 0. volumes_raw = 16'h0000. dac_off = 4'b1111.
- Per envelope channel state: vol[3:0], timer[3:0], dir_l, per_l[2:0], stopped.
- Trigger (trig[i]=1):
  - vol <= reg[7:4]; dir_l <= reg[3]; per_l <= reg[2:0].
  - timer <= (reg[2:0]==0) ? TIMER_ZERO_AS : reg[2:0].
  - stopped <= 0.
- Tick (env_tick=1, no trigger on that channel this cycle):
  - If per_l==0 or stopped: no change.
  - Else if timer > 1: timer decrements.
  - Else (timer == 1): timer reloads to per_l, and:
    - dir_l=1 and vol<15: vol+1.
    - dir_l=0 and vol>0: vol-1.
    - Otherwise: stopped <= 1, vol unchanged.
- Trigger and tick in the same cycle on one channel: the trigger wins and the tick is discarded for that channel.
- Wave channel volume: level 00 -> 0, 01 -> WAVE_FULL, 10 -> WAVE_FULL>>1 (7), 11 -> WAVE_FULL>>2 (3). trig[2] has no internal effect.
- Outputs: all registered.
  - volumes_raw nibble = ch_on[i] ? vol : 4'h0.
  - dac_off[i] = (reg[7:3]==0) for pulse/noise; (nr32_level==0) for wave.
  - Latency: exactly 1 clk from the trig/env_tick/ch_on/register edge to the output change.
- ch_on low: envelope state keeps running; only the output nibble is forced to 0.
- vol never wraps: it saturates at 15 and 0 and sets stopped.
- nrx2_wr without the optional feature: ignored. Register changes take effect at the next trigger only (dac_off still follows the live register).

Optional Feature:
- APU_ENV_ZOMBIE_EN defined: on nrx2_wr[i] with ch_on[i]=1, apply these modulo-16 steps in order, using the latched dir_l/per_l and stopped from before the write:
  1. If per_l==0 and !stopped: vol+1.
  2. Else if dir_l==0: vol+2.
  3. If the new reg[3] != dir_l: vol = 16 - vol.
  4. Then dir_l/per_l <= new reg fields. Timer and stopped are unchanged.
- If a trigger coincides with the write, the trigger wins.
- Undefined: nrx2_wr is ignored entirely; the port remains.

Test Plan:
- Reset then release, all inputs 0 -> volumes_raw=16'h0000, dac_off=4'b1111.
- nr12=8'hF3, ch_on[0]=1, trig[0] -> volumes_raw[3:0]=F one clk later. After 3 env_ticks -> E. After 45 ticks total -> 0 and stopped; a further tick keeps 0.
- nr22=8'h09 (init 0, up, period 1), trig[1], 20 ticks -> pulse2 nibble 0,1,…,F then holds F. dac_off[1]=0.
- nr42=8'hA0 (period 0), trig[3], 10 ticks -> noise nibble stays A. Trig and tick in the same cycle -> nibble reloads A and the timer restarts from reload.
- Wave: nr32_level 01/10/11/00 with ch_on[2]=1 -> nibble F/7/3/0. dac_off[2] set only for 00. ch_on[2]=0 -> 0.
- APU_ENV_ZOMBIE_EN: pulse1 running at vol 5, dir down, per 2; write nr12=8'h5A with nrx2_wr[0] -> vol becomes 7, then 16-7=9 (nibble 9). Without the macro -> nibble stays 5.
